pipeline_stall_ctrl: RTL and testbench

- Parametrised successor to the fixed six-stage stall controller.
- Generates per-stage hold (`stall`) and discard (`kill`) controls for an N-stage in-order pipeline, plus a PC-redirect strobe.
- Unlike the fixed controller, it never drops a control-flow flush that arrives while a downstream stall is active: the flush is latched and replayed.
- Also provides a consecutive-stall watchdog and a saturating stall-cycle performance counter.
- Sits beside the pipeline registers; every stage's pipeline register consumes `stall[i]` and `kill[i]`.

---
 rtl/pipeline_stall_ctrl.sv | 118 +++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Per-stage stall/kill generation for an N-stage in-order pipeline, with
// deferred (replayed) control-flow flushes, a stall watchdog and a stall-cycle counter.
module pipeline_stall_ctrl #(
  parameter int NUM_STAGES = 6,
  parameter int SRC_W      = 3,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic                  flush_req,
  input  logic [SRC_W-1:0]      flush_src,
  input  logic                  cnt_clr,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] kill,
  output logic                  redirect,
  output logic [SRC_W-1:0]      redirect_src,
  output logic                  hang,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int               RUN_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(TIMEOUT - 1);

  logic             pend_v_q, pend_v_d;
  logic [SRC_W-1:0] pend_src_q, pend_src_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic             hang_q, hang_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic             in_v, eff_v, any_req, blocked, any_stall;
  logic [SRC_W-1:0] eff_src;
  int               h_idx;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    stall        = '0;
    kill         = '0;
    redirect     = 1'b0;
    redirect_src = '0;
    pend_v_d     = 1'b0;
    pend_src_d   = '0;

    // An incoming flush from an older stage (higher index) supersedes the pending one.
    in_v = flush_req && (flush_src != '0) && (int'(flush_src) < NUM_STAGES);
    if (in_v && (!pend_v_q || flush_src >= pend_src_q)) begin
      eff_v   = 1'b1;
      eff_src = flush_src;
    end else begin
      eff_v   = pend_v_q;
      eff_src = pend_src_q;
    end

    any_req = |stall_req;
    h_idx   = 0;
    for (int j = 0; j < NUM_STAGES; j++) begin
      if (stall_req[j]) h_idx = j;
    end
    blocked = eff_v && any_req && (h_idx >= int'(eff_src));

    if (rst) begin
      // outputs stay at their zero defaults while reset is held
    end else if (!rdy) begin
      stall      = '1;
      pend_v_d   = eff_v;
      pend_src_d = eff_v ? eff_src : '0;
    end else if (eff_v && !blocked) begin
      redirect     = 1'b1;
      redirect_src = eff_src;
      for (int j = 0; j < NUM_STAGES; j++) begin
        kill[j] = (j >= 1) && (j < int'(eff_src));
      end
    end else begin
      for (int j = 0; j < NUM_STAGES; j++) begin
        stall[j] = any_req && (j <= h_idx);
        kill[j]  = any_req && (j == h_idx + 1);
      end
      pend_v_d   = eff_v;
      pend_src_d = eff_v ? eff_src : '0;
    end
  end

  always_comb begin
    any_stall = |stall;
    if (!any_stall)                 run_cnt_d = '0;
    else if (run_cnt_q == RUN_MAX)  run_cnt_d = run_cnt_q;
    else                            run_cnt_d = run_cnt_q + 1'b1;

    hang_d = cnt_clr ? 1'b0 : (hang_q || (any_stall && run_cnt_q == RUN_MAX));

    if (cnt_clr)                                       stall_cycles_d = '0;
    else if (any_stall && rdy && stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + 1'b1;
    else                                               stall_cycles_d = stall_cycles_q;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v_q       <= 1'b0;
      pend_src_q     <= '0;
      run_cnt_q      <= '0;
      hang_q         <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      pend_v_q       <= pend_v_d;
      pend_src_q     <= pend_src_d;
      run_cnt_q      <= run_cnt_d;
      hang_q         <= hang_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign hang         = hang_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios plus randomized
// traffic compared against an arithmetic reference model of the stall/flush rules.
module tb_pipeline_stall_ctrl;

  localparam int N  = 6;
  localparam int SW = 3;
  localparam int TO = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rdy = 1'b1;
  logic [N-1:0]  stall_req = '0;
  logic          flush_req = 1'b0;
  logic [SW-1:0] flush_src = '0;
  logic          cnt_clr = 1'b0;
  logic [N-1:0]  stall, kill;
  logic          redirect;
  logic [SW-1:0] redirect_src;
  logic          hang;
  logic [CW-1:0] stall_cycles;

  int n_vec = 0;
  int n_err = 0;

  // reference model state and expectations
  bit            m_pv, m_hang;
  int            m_ps, m_run, m_cyc;
  bit            n_pv;
  int            n_ps;
  logic [N-1:0]  e_stall, e_kill;
  logic          e_redir;
  logic [SW-1:0] e_rsrc;

  pipeline_stall_ctrl #(.NUM_STAGES(N), .SRC_W(SW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_req(stall_req), .flush_req(flush_req),
    .flush_src(flush_src), .cnt_clr(cnt_clr), .stall(stall), .kill(kill),
    .redirect(redirect), .redirect_src(redirect_src), .hang(hang),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic model_eval();
    int  h, es;
    bit  in_v, ev;
    in_v = flush_req && flush_src >= 1 && int'(flush_src) <= N - 1;
    if (in_v && (!m_pv || int'(flush_src) >= m_ps)) begin ev = 1; es = int'(flush_src); end
    else begin ev = m_pv; es = m_ps; end
    h = -1;
    for (int i = 0; i < N; i++) if (stall_req[i]) h = i;
    e_stall = '0; e_kill = '0; e_redir = 1'b0; e_rsrc = '0; n_pv = 0; n_ps = 0;
    if (rst) begin
    end else if (!rdy) begin
      e_stall = N'((1 << N) - 1);
      n_pv = ev; n_ps = ev ? es : 0;
    end else if (ev && h < es) begin
      e_redir = 1'b1; e_rsrc = SW'(es);
      e_kill  = N'((1 << es) - 2);
    end else begin
      e_stall = N'((1 << (h + 1)) - 1);
      if (h >= 0 && h + 1 < N) e_kill = N'(1 << (h + 1));
      n_pv = ev; n_ps = ev ? es : 0;
    end
  endtask

  task automatic model_reset();
    m_pv = 0; m_ps = 0; m_run = 0; m_hang = 0; m_cyc = 0;
  endtask

  task automatic model_edge();
    bit any;
    if (rst) begin model_reset(); return; end
    any = (e_stall != '0);
    if (cnt_clr) m_hang = 0;
    else if (any && m_run == TO - 1) m_hang = 1;
    m_run = !any ? 0 : (m_run < TO - 1 ? m_run + 1 : m_run);
    if (cnt_clr) m_cyc = 0;
    else if (any && rdy && m_cyc < (1 << CW) - 1) m_cyc = m_cyc + 1;
    m_pv = n_pv; m_ps = n_ps;
  endtask

  task automatic drive(input logic [N-1:0] sr, input logic fr, input logic [SW-1:0] fs);
    stall_req = sr; flush_req = fr; flush_src = fs;
    #1;
    model_eval();
  endtask

  task automatic clock();
    model_eval();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    drive('1, 1'b1, 3'd3);
    n_vec++;
    if ({stall, kill, redirect, redirect_src, hang, stall_cycles} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got stall=%b kill=%b redir=%b src=%0d hang=%b cyc=%0d want all 0",
               stall, kill, redirect, redirect_src, hang, stall_cycles);
    end
    clock();
    rst = 1'b0;
    drive('0, 1'b0, '0);
    clock();
  endtask

  task automatic test_idle();
    drive('0, 1'b0, '0);
    n_vec++;
    if ({stall, kill, redirect} !== '0) begin
      n_err++;
      $display("FAIL idle_comb got stall=%b kill=%b redir=%b want 000000 000000 0", stall, kill, redirect);
    end
    clock();
    n_vec++;
    if (stall_cycles !== 4'd0) begin
      n_err++;
      $display("FAIL idle_counter got %0d want 0", stall_cycles);
    end
  endtask

  task automatic test_mem_stall();
    drive(6'b010000, 1'b0, '0);
    n_vec++;
    if (stall !== 6'b011111 || kill !== 6'b100000 || redirect !== 1'b0) begin
      n_err++;
      $display("FAIL mem_stall got stall=%b kill=%b redir=%b want 011111 100000 0", stall, kill, redirect);
    end
    clock();
    n_vec++;
    if (stall_cycles !== 4'd1) begin
      n_err++;
      $display("FAIL mem_stall_count got %0d want 1", stall_cycles);
    end
    drive(6'b000100, 1'b0, '0);
    n_vec++;
    if (stall !== 6'b000111 || kill !== 6'b001000) begin
      n_err++;
      $display("FAIL ex_stall got stall=%b kill=%b want 000111 001000", stall, kill);
    end
    clock();
    n_vec++;
    if (stall_cycles !== 4'd2) begin
      n_err++;
      $display("FAIL ex_stall_count got %0d want 2", stall_cycles);
    end
    drive('0, 1'b0, '0);
    clock();
  endtask

  task automatic test_ex_flush();
    drive('0, 1'b1, 3'd3);
    n_vec++;
    if (kill !== 6'b000110 || stall !== 6'b000000 || redirect !== 1'b1 || redirect_src !== 3'd3) begin
      n_err++;
      $display("FAIL ex_flush got kill=%b stall=%b redir=%b src=%0d want 000110 000000 1 3",
               kill, stall, redirect, redirect_src);
    end
    clock();
    drive('0, 1'b0, '0);
    n_vec++;
    if (redirect !== 1'b0) begin
      n_err++;
      $display("FAIL ex_flush_once got redir=%b want 0", redirect);
    end
    clock();
  endtask

  task automatic test_deferred();
    drive(6'b010000, 1'b1, 3'd3);
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if (redirect !== 1'b0 || stall !== 6'b011111) begin
        n_err++;
        $display("FAIL deferred_hold cyc=%0d got redir=%b stall=%b want 0 011111", c, redirect, stall);
      end
      clock();
      drive(6'b010000, 1'b0, '0);
    end
    drive('0, 1'b0, '0);
    n_vec++;
    if (redirect !== 1'b1 || kill !== 6'b000110 || redirect_src !== 3'd3 || stall !== '0) begin
      n_err++;
      $display("FAIL deferred_apply got redir=%b kill=%b src=%0d stall=%b want 1 000110 3 000000",
               redirect, kill, redirect_src, stall);
    end
    clock();
    drive('0, 1'b0, '0);
    n_vec++;
    if (redirect !== 1'b0) begin
      n_err++;
      $display("FAIL deferred_once got redir=%b want 0", redirect);
    end
    clock();
  endtask

  task automatic test_merge();
    logic [SW-1:0] first_src [2];
    logic [SW-1:0] second_src [2];
    first_src[0] = 3'd2; second_src[0] = 3'd3;
    first_src[1] = 3'd3; second_src[1] = 3'd2;
    for (int k = 0; k < 2; k++) begin
      drive(6'b010000, 1'b1, first_src[k]);
      clock();
      drive(6'b010000, 1'b1, second_src[k]);
      n_vec++;
      if (redirect !== 1'b0) begin
        n_err++;
        $display("FAIL merge_hold case=%0d got redir=%b want 0", k, redirect);
      end
      clock();
      drive('0, 1'b0, '0);
      n_vec++;
      if (redirect !== 1'b1 || redirect_src !== 3'd3 || kill !== 6'b000110) begin
        n_err++;
        $display("FAIL merge_apply case=%0d got redir=%b src=%0d kill=%b want 1 3 000110",
                 k, redirect, redirect_src, kill);
      end
      clock();
    end
  endtask

  task automatic test_invalid_src();
    logic [SW-1:0] bad [3];
    bad[0] = 3'd0; bad[1] = 3'd6; bad[2] = 3'd7;
    for (int k = 0; k < 3; k++) begin
      drive('0, 1'b1, bad[k]);
      clock();
      drive('0, 1'b0, '0);
      n_vec++;
      if (redirect !== 1'b0 || kill !== '0) begin
        n_err++;
        $display("FAIL invalid_src src=%0d got redir=%b kill=%b want 0 000000", bad[k], redirect, kill);
      end
      clock();
    end
  endtask

  task automatic test_freeze();
    rdy = 1'b0;
    drive('0, 1'b1, 3'd2);
    n_vec++;
    if (stall !== 6'b111111 || kill !== '0 || redirect !== 1'b0) begin
      n_err++;
      $display("FAIL freeze got stall=%b kill=%b redir=%b want 111111 000000 0", stall, kill, redirect);
    end
    clock();
    rdy = 1'b1;
    drive('0, 1'b0, '0);
    n_vec++;
    if (redirect !== 1'b1 || redirect_src !== 3'd2 || kill !== 6'b000010) begin
      n_err++;
      $display("FAIL freeze_release got redir=%b src=%0d kill=%b want 1 2 000010",
               redirect, redirect_src, kill);
    end
    clock();
  endtask

  task automatic test_reset_mid_deferral();
    drive(6'b010000, 1'b1, 3'd4);
    clock();
    rst = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if ({stall, kill, redirect, hang, stall_cycles} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_deferral got stall=%b kill=%b redir=%b hang=%b cyc=%0d want all 0",
               stall, kill, redirect, hang, stall_cycles);
    end
    clock();
    rst = 1'b0;
    drive('0, 1'b0, '0);
    n_vec++;
    if (redirect !== 1'b0) begin
      n_err++;
      $display("FAIL reset_drops_pending got redir=%b want 0", redirect);
    end
    clock();
  endtask

  task automatic test_watchdog();
    drive('0, 1'b0, '0);
    clock();
    for (int k = 1; k <= 8; k++) begin
      drive(6'b000001, 1'b0, '0);
      clock();
      n_vec++;
      if (hang !== (k == 8)) begin
        n_err++;
        $display("FAIL watchdog edge=%0d got hang=%b want %0d", k, hang, (k == 8));
      end
    end
    drive('0, 1'b0, '0);
    clock();
    n_vec++;
    if (hang !== 1'b1) begin
      n_err++;
      $display("FAIL hang_sticky got %b want 1", hang);
    end
    cnt_clr = 1'b1;
    drive(6'b000001, 1'b0, '0);
    clock();
    cnt_clr = 1'b0;
    n_vec++;
    if (hang !== 1'b0 || stall_cycles !== 4'd0) begin
      n_err++;
      $display("FAIL cnt_clr_wins got hang=%b cyc=%0d want 0 0", hang, stall_cycles);
    end
    drive(6'b000001, 1'b0, '0);
    clock();
    rst = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if (hang !== 1'b0 || stall_cycles !== 4'd0) begin
      n_err++;
      $display("FAIL async_reset got hang=%b cyc=%0d want 0 0", hang, stall_cycles);
    end
    clock();
    rst = 1'b0;
    drive('0, 1'b0, '0);
    clock();
  endtask

  task automatic test_random();
    logic [N-1:0] sr;
    for (int c = 0; c < 400; c++) begin
      rdy     = ($urandom_range(0, 9) != 0);
      cnt_clr = ($urandom_range(0, 49) == 0);
      sr      = ($urandom_range(0, 2) == 0) ? '0 : (N'($urandom) & N'($urandom));
      drive(sr, ($urandom_range(0, 2) == 0), SW'($urandom));
      n_vec++;
      if ({stall, kill, redirect, redirect_src} !== {e_stall, e_kill, e_redir, e_rsrc}) begin
        n_err++;
        $display("FAIL rand_comb cyc=%0d got stall=%b kill=%b redir=%b src=%0d want %b %b %b %0d",
                 c, stall, kill, redirect, redirect_src, e_stall, e_kill, e_redir, e_rsrc);
      end
      clock();
      n_vec++;
      if (hang !== m_hang || int'(stall_cycles) != m_cyc) begin
        n_err++;
        $display("FAIL rand_state cyc=%0d got hang=%b cyc=%0d want %b %0d",
                 c, hang, stall_cycles, m_hang, m_cyc);
      end
    end
    rdy = 1'b1;
    cnt_clr = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle();
    test_mem_stall();
    test_ex_flush();
    test_deferred();
    test_merge();
    test_invalid_src();
    test_freeze();
    test_reset_mid_deferral();
    test_watchdog();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
